// File: rtl/sb_burst_master.sv
// sb_burst_master: burst master for a shared wired-OR system bus.
// Takes one read or write command, arbitrates, runs the burst, reports done.
//
// Ports:
//   sb_clock_i, sb_reset_n_i        clock, async active-low reset
//   cmd_*                           command handshake and fields
//   wr_data_i/wr_valid_i/wr_ready_o write-data stream
//   rd_data_o/rd_valid_o            read beats (no backpressure)
//   done_o/error_o                  completion pulse and status
//   sb_*_o                          bus drive, zero when not owned
//   sb_*_i                          wired-OR bus inputs
module sb_burst_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        sb_clock_i,
  input  logic        sb_reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_read_n_write_i,
  input  logic [31:0] cmd_address_i,
  input  logic [3:0]  cmd_byte_enables_i,
  input  logic [8:0]  cmd_len_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        done_o,
  output logic        error_o,
  output logic        sb_request_o,
  input  logic        sb_grant_i,
  output logic        sb_begin_transaction_o,
  output logic        sb_end_transaction_o,
  output logic        sb_data_valid_o,
  output logic        sb_read_n_write_o,
  output logic [31:0] sb_address_data_o,
  output logic [3:0]  sb_byte_enables_o,
  output logic [7:0]  sb_burst_size_o,
  input  logic [31:0] sb_address_data_i,
  input  logic        sb_end_transaction_i,
  input  logic        sb_data_valid_i,
  input  logic        sb_busy_i,
  input  logic        sb_error_i
);

  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEGIN,
    S_RD_DATA,
    S_RD_END,
    S_WR_DATA,
    S_WR_END,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic          rnw_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [8:0]    len_q;
  logic [8:0]    beat_q;
  logic          err_q, err_d;
  logic          end_pend_q, end_pend_d;
  logic [TW-1:0] tmo_q;
  logic          wr_pend_q;
  logic [31:0]   wr_word_q;
  logic          rd_valid_q;
  logic [31:0]   rd_data_q;

  logic          cmd_take;
  logic          rd_beat;
  logic          wr_beat;
  logic          wr_take;
  logic          bus_beat;
  logic          tmo_hit;
  logic          last_beat;
  logic [8:0]    len_m1;

  assign len_m1    = len_q - 9'd1;
  assign last_beat = (beat_q == len_m1);
  assign tmo_hit   = (tmo_q == TMO_LAST);

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

  always_comb begin
    state_d                = state_q;
    err_d                  = err_q;
    end_pend_d             = end_pend_q;
    cmd_take               = 1'b0;
    rd_beat                = 1'b0;
    wr_beat                = 1'b0;
    wr_take                = 1'b0;
    bus_beat               = 1'b0;
    cmd_ready_o            = 1'b0;
    wr_ready_o             = 1'b0;
    done_o                 = 1'b0;
    error_o                = 1'b0;
    sb_request_o           = 1'b0;
    sb_begin_transaction_o = 1'b0;
    sb_end_transaction_o   = 1'b0;
    sb_data_valid_o        = 1'b0;
    sb_read_n_write_o      = 1'b0;
    sb_address_data_o      = 32'h0;
    sb_byte_enables_o      = 4'h0;
    sb_burst_size_o        = 8'h0;

    unique case (state_q)
      S_IDLE: begin
        // ready is held low while reset is asserted
        cmd_ready_o = sb_reset_n_i;
        if (cmd_valid_i) begin
          cmd_take   = 1'b1;
          end_pend_d = 1'b0;
          if (cmd_len_i == 9'd0 || cmd_len_i > 9'd256) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        sb_request_o = 1'b1;
        if (sb_grant_i) begin
          state_d = S_BEGIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_BEGIN: begin
        sb_begin_transaction_o = 1'b1;
        sb_address_data_o      = addr_q;
        sb_byte_enables_o      = be_q;
        sb_burst_size_o        = len_m1[7:0];
        sb_read_n_write_o      = rnw_q;
        if (sb_error_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = rnw_q ? S_RD_DATA : S_WR_DATA;
        end
      end

      S_RD_DATA: begin
        if (sb_error_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (sb_data_valid_i) begin
          rd_beat  = 1'b1;
          bus_beat = 1'b1;
          if (last_beat) begin
            state_d = sb_end_transaction_i ? S_DONE : S_RD_END;
          end
        end else if (tmo_hit) begin
          // begin was issued, so close the transaction
          err_d      = 1'b1;
          end_pend_d = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_RD_END: begin
        bus_beat = sb_data_valid_i;
        if (sb_error_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (sb_end_transaction_i) begin
          state_d = S_DONE;
        end else if (tmo_hit && !sb_data_valid_i) begin
          err_d      = 1'b1;
          end_pend_d = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_WR_DATA: begin
        wr_ready_o        = !wr_pend_q;
        sb_data_valid_o   = wr_pend_q;
        sb_address_data_o = wr_pend_q ? wr_word_q : 32'h0;
        if (sb_error_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (wr_pend_q) begin
          if (!sb_busy_i) begin
            wr_beat  = 1'b1;
            bus_beat = 1'b1;
            if (last_beat) begin
              state_d = S_WR_END;
            end
          end
        end else if (wr_valid_i) begin
          wr_take = 1'b1;
        end
      end

      S_WR_END: begin
        sb_end_transaction_o = 1'b1;
        if (sb_error_i) begin
          err_d = 1'b1;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        done_o               = 1'b1;
        error_o              = err_q;
        sb_end_transaction_o = end_pend_q;
        state_d              = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state_q    <= S_IDLE;
      rnw_q      <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      len_q      <= 9'h0;
      beat_q     <= 9'h0;
      err_q      <= 1'b0;
      end_pend_q <= 1'b0;
      tmo_q      <= '0;
      wr_pend_q  <= 1'b0;
      wr_word_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      end_pend_q <= end_pend_d;

      if (cmd_take) begin
        rnw_q  <= cmd_read_n_write_i;
        addr_q <= cmd_address_i;
        be_q   <= cmd_byte_enables_i;
        len_q  <= cmd_len_i;
        beat_q <= 9'h0;
      end else if (rd_beat || wr_beat) begin
        beat_q <= beat_q + 9'd1;
      end

      if (state_d != state_q || bus_beat) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      rd_valid_q <= rd_beat;
      if (rd_beat) begin
        rd_data_q <= sb_address_data_i;
      end

      if (wr_take) begin
        wr_pend_q <= 1'b1;
        wr_word_q <= wr_data_i;
      end else if (wr_beat || state_d != S_WR_DATA) begin
        wr_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sb_burst_master.sv
// tb_sb_burst_master: directed and randomized bursts against sb_burst_master.
// Expected data comes from the bench's own beat tables and protocol rules.
module tb_sb_burst_master;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_read_n_write_i = 1'b0;
  logic [31:0] cmd_address_i = 32'h0;
  logic [3:0]  cmd_byte_enables_i = 4'h0;
  logic [8:0]  cmd_len_i = 9'h0;
  logic [31:0] wr_data_i = 32'h0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        done_o;
  logic        error_o;
  logic        sb_request_o;
  logic        sb_grant_i = 1'b0;
  logic        sb_begin_transaction_o;
  logic        sb_end_transaction_o;
  logic        sb_data_valid_o;
  logic        sb_read_n_write_o;
  logic [31:0] sb_address_data_o;
  logic [3:0]  sb_byte_enables_o;
  logic [7:0]  sb_burst_size_o;
  logic [31:0] sb_address_data_i = 32'h0;
  logic        sb_end_transaction_i = 1'b0;
  logic        sb_data_valid_i = 1'b0;
  logic        sb_busy_i = 1'b0;
  logic        sb_error_i = 1'b0;

  always #5 clk = ~clk;

  sb_burst_master #(.TIMEOUT_CYCLES(T)) dut (
    .sb_clock_i(clk),
    .sb_reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_read_n_write_i(cmd_read_n_write_i),
    .cmd_address_i(cmd_address_i),
    .cmd_byte_enables_i(cmd_byte_enables_i),
    .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i),
    .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .done_o(done_o),
    .error_o(error_o),
    .sb_request_o(sb_request_o),
    .sb_grant_i(sb_grant_i),
    .sb_begin_transaction_o(sb_begin_transaction_o),
    .sb_end_transaction_o(sb_end_transaction_o),
    .sb_data_valid_o(sb_data_valid_o),
    .sb_read_n_write_o(sb_read_n_write_o),
    .sb_address_data_o(sb_address_data_o),
    .sb_byte_enables_o(sb_byte_enables_o),
    .sb_burst_size_o(sb_burst_size_o),
    .sb_address_data_i(sb_address_data_i),
    .sb_end_transaction_i(sb_end_transaction_i),
    .sb_data_valid_i(sb_data_valid_i),
    .sb_busy_i(sb_busy_i),
    .sb_error_i(sb_error_i)
  );

  wire [48:0] bus_vec = {sb_request_o, sb_begin_transaction_o,
    sb_end_transaction_o, sb_data_valid_o, sb_read_n_write_o,
    sb_address_data_o, sb_byte_enables_o, sb_burst_size_o};
  wire [84:0] rest_vec = {wr_ready_o, rd_valid_o, rd_data_o,
    done_o, error_o, bus_vec};

  int total = 0;
  int bad = 0;

  // monitor state, written only by the monitor process
  logic [31:0] rd_q[$];
  logic [31:0] wb_q[$];
  int n_beg = 0, n_end = 0, n_done = 0, n_dv = 0, n_req = 0;
  logic        last_err = 1'b0;
  logic [31:0] beg_addr = 32'h0;
  logic [7:0]  beg_size = 8'h0;
  logic        beg_rnw = 1'b0;
  logic [3:0]  beg_be = 4'h0;

  always @(negedge clk) begin
    if (rd_valid_o) rd_q.push_back(rd_data_o);
    if (sb_data_valid_o) begin
      n_dv++;
      if (!sb_busy_i) wb_q.push_back(sb_address_data_o);
    end
    if (sb_begin_transaction_o) begin
      n_beg++;
      beg_addr = sb_address_data_o;
      beg_size = sb_burst_size_o;
      beg_rnw  = sb_read_n_write_o;
      beg_be   = sb_byte_enables_o;
    end
    if (sb_end_transaction_o) n_end++;
    if (sb_request_o) n_req++;
    if (done_o) begin
      n_done++;
      last_err = error_o;
    end
  end

  logic [31:0] rdat [256];
  logic [31:0] wdat [256];
  int d0, r0, w0, b0, e0, q0, v0;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    d0 = n_done;
    r0 = rd_q.size();
    w0 = wb_q.size();
    b0 = n_beg;
    e0 = n_end;
    q0 = n_req;
    v0 = n_dv;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) begin
      rdat[i] = $urandom;
      wdat[i] = $urandom;
    end
  endtask

  task automatic issue(input logic rnw, input logic [31:0] a,
                       input logic [3:0] be, input logic [8:0] len);
    int k = 0;
    cmd_valid_i        = 1'b1;
    cmd_read_n_write_i = rnw;
    cmd_address_i      = a;
    cmd_byte_enables_i = be;
    cmd_len_i          = len;
    @(negedge clk);
    while (!cmd_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    cmd_len_i   = 9'h0;
  endtask

  task automatic grant_begin(input int dly);
    @(negedge clk);
    chk("req_latency", sb_request_o, 1);
    chk("ready_low_busy", cmd_ready_o, 0);
    tick();
    repeat (dly) tick();
    sb_grant_i = 1'b1;
    tick();
    sb_grant_i = 1'b0;
    @(negedge clk);
    chk("grant_to_begin", sb_begin_transaction_o, 1);
    tick();
  endtask

  task automatic drive_read(input int len, input int gap_max,
                            input bit coinc, input int end_dly,
                            input int extra);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      sb_data_valid_i      = 1'b1;
      sb_address_data_i    = rdat[i];
      sb_end_transaction_i = coinc && (i == len - 1);
      tick();
      sb_data_valid_i      = 1'b0;
      sb_address_data_i    = 32'h0;
      sb_end_transaction_i = 1'b0;
    end
    if (!coinc) begin
      for (int j = 0; j < end_dly; j++) begin
        sb_data_valid_i   = (j < extra);
        sb_address_data_i = (j < extra) ? $urandom : 32'h0;
        tick();
      end
      sb_data_valid_i      = 1'b0;
      sb_address_data_i    = 32'h0;
      sb_end_transaction_i = 1'b1;
      tick();
      sb_end_transaction_i = 1'b0;
    end
  endtask

  task automatic drive_write(input int len, input int busy_mode,
                             input int err_beat);
    int widx = 0;
    int hold = 0;
    int k = 0;
    bit err_done = 0;
    bit chk_next = 0;
    while (n_done == d0 && k < 400) begin
      wr_valid_i = (widx < len);
      wr_data_i  = (widx < len) ? wdat[widx] : 32'h0;
      sb_busy_i  = 1'b0;
      sb_error_i = 1'b0;
      if (sb_data_valid_o) begin
        if (busy_mode == 1 && wb_q.size() - w0 == 1 && hold < 2) begin
          sb_busy_i = 1'b1;
          hold++;
        end else if (busy_mode == 2) begin
          sb_busy_i = ($urandom_range(3, 0) == 0);
        end
        if (err_beat >= 0 && !err_done && wb_q.size() - w0 == err_beat) begin
          sb_error_i = 1'b1;
          sb_busy_i  = 1'b0;
          err_done   = 1;
        end
      end
      @(negedge clk);
      if (chk_next) begin
        chk("bus_zero_after_err", bus_vec, 0);
        chk_next = 0;
      end
      if (sb_error_i) chk_next = 1;
      if (wr_valid_i && wr_ready_o) widx++;
      tick();
      k++;
    end
    wr_valid_i = 1'b0;
    wr_data_i  = 32'h0;
    sb_busy_i  = 1'b0;
    sb_error_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_wait", (n_done != d0), 1);
  endtask

  task automatic run_read(input logic [31:0] a, input logic [3:0] be,
                          input int len, input int gap_max, input bit coinc,
                          input int end_dly, input int extra);
    int mism = 0;
    snap();
    issue(1'b1, a, be, 9'(len));
    grant_begin($urandom_range(3, 0));
    drive_read(len, gap_max, coinc, end_dly, extra);
    wait_done(40);
    repeat (2) tick();
    for (int i = 0; i < len; i++) begin
      if (r0 + i >= rd_q.size()) mism++;
      else if (rd_q[r0 + i] !== rdat[i]) mism++;
    end
    chk("rd_count", rd_q.size() - r0, len);
    chk("rd_data_mism", mism, 0);
    chk("rd_done_cnt", n_done - d0, 1);
    chk("rd_done_err", last_err, 0);
    chk("rd_beg_cnt", n_beg - b0, 1);
    chk("rd_beg_addr", beg_addr, a);
    chk("rd_beg_size", beg_size, len - 1);
    chk("rd_beg_rnw", beg_rnw, 1);
    chk("rd_beg_be", beg_be, be);
    chk("rd_end_cnt", n_end - e0, 0);
  endtask

  task automatic run_write(input logic [31:0] a, input logic [3:0] be,
                           input int len, input int busy_mode,
                           input int err_beat);
    int mism = 0;
    int nchk;
    snap();
    issue(1'b0, a, be, 9'(len));
    grant_begin($urandom_range(3, 0));
    drive_write(len, busy_mode, err_beat);
    wait_done(10);
    repeat (2) tick();
    nchk = (err_beat >= 0) ? err_beat : len;
    for (int i = 0; i < nchk; i++) begin
      if (w0 + i >= wb_q.size()) mism++;
      else if (wb_q[w0 + i] !== wdat[i]) mism++;
    end
    chk("wr_data_mism", mism, 0);
    chk("wr_done_cnt", n_done - d0, 1);
    chk("wr_done_err", last_err, (err_beat >= 0));
    chk("wr_end_cnt", n_end - e0, (err_beat >= 0) ? 0 : 1);
    chk("wr_beg_size", beg_size, len - 1);
    chk("wr_beg_rnw", beg_rnw, 0);
    chk("wr_beg_addr", beg_addr, a);
    if (err_beat < 0) chk("wr_count", wb_q.size() - w0, len);
    if (busy_mode == 1) chk("wr_dv_cycles", n_dv - v0, len + 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ln;
    fill_rand();
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_outs", {cmd_ready_o, rest_vec}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_reset_ready", cmd_ready_o, 1);
    chk("post_reset_outs", rest_vec, 0);
    tick();

    // single-beat read, end three cycles after the data
    rdat[0] = 32'hDEADBEEF;
    run_read(32'h0000_1000, 4'hF, 1, 0, 1'b0, 2, 0);
    chk("rd_deadbeef", rd_q[r0], 32'hDEADBEEF);

    // four-beat write, beat 2 held by busy for two cycles
    fill_rand();
    run_write(32'h0000_2000, 4'hF, 4, 1, -1);

    // full 256-beat read, end coincident with last beat
    fill_rand();
    run_read(32'hABCD_0000, 4'h3, 256, 1, 1'b1, 0, 0);

    // bus error on write beat 3 of 8
    fill_rand();
    run_write(32'h0000_3000, 4'hC, 8, 0, 2);

    // read with stray beats after the last one
    fill_rand();
    run_read(32'h0000_4000, 4'h1, 4, 1, 1'b0, 5, 2);

    // no grant: request held T cycles then aborted
    snap();
    issue(1'b1, 32'h0000_5000, 4'hF, 9'd4);
    wait_done(3 * T);
    repeat (2) tick();
    chk("tmo_req_cycles", n_req - q0, T);
    chk("tmo_done_cnt", n_done - d0, 1);
    chk("tmo_done_err", last_err, 1);
    chk("tmo_no_begin", n_beg - b0, 0);
    chk("tmo_no_end", n_end - e0, 0);

    // read data stalls after one beat: abort closes the transaction
    fill_rand();
    snap();
    issue(1'b1, 32'h0000_6000, 4'hF, 9'd3);
    grant_begin(0);
    sb_data_valid_i   = 1'b1;
    sb_address_data_i = rdat[0];
    tick();
    sb_data_valid_i   = 1'b0;
    sb_address_data_i = 32'h0;
    wait_done(3 * T);
    repeat (2) tick();
    chk("rdtmo_rd_count", rd_q.size() - r0, 1);
    chk("rdtmo_done_err", last_err, 1);
    chk("rdtmo_end_cnt", n_end - e0, 1);

    // illegal lengths complete at once with error and no request
    snap();
    issue(1'b1, 32'h0, 4'hF, 9'd0);
    @(negedge clk);
    chk("len0_no_req", sb_request_o, 0);
    chk("len0_done", done_o, 1);
    chk("len0_err", error_o, 1);
    wait_done(4);
    repeat (2) tick();
    chk("len0_req_cnt", n_req - q0, 0);
    snap();
    issue(1'b0, 32'h0, 4'hF, 9'd300);
    wait_done(4);
    repeat (2) tick();
    chk("len300_err", last_err, 1);
    chk("len300_req_cnt", n_req - q0, 0);

    // reset in the middle of a read burst
    fill_rand();
    snap();
    issue(1'b1, 32'h0000_7000, 4'hF, 9'd8);
    grant_begin(1);
    for (int i = 0; i < 3; i++) begin
      sb_data_valid_i   = 1'b1;
      sb_address_data_i = rdat[i];
      tick();
    end
    sb_data_valid_i   = 1'b0;
    sb_address_data_i = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {cmd_ready_o, rest_vec}, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_no_end", n_end - e0, 0);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_ready", cmd_ready_o, 1);
    fill_rand();
    run_read(32'h0000_8000, 4'hF, 5, 2, 1'b0, 1, 0);

    // randomized bursts
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      ln = $urandom_range(24, 1);
      if ($urandom_range(1, 0) == 1)
        run_read($urandom, 4'($urandom), ln, 3,
                 1'($urandom_range(1, 0)), $urandom_range(6, 1),
                 $urandom_range(2, 0));
      else
        run_write($urandom, 4'($urandom), ln, 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
